// File: rtl/cache_controller_nway_if.sv
// Signal bundle between the requester/backing memory and cache_controller_nway.
// master = requester plus memory model, slave = the cache controller.
interface cache_controller_nway_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              req_valid;
    logic              opcode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              req_ready;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport master (
        output req_valid, opcode, addr, wdata, mem_rdata, mem_ack,
        input  req_ready, rdata, ready, mem_req, mem_we, mem_addr, mem_wdata,
               hit_cnt, miss_cnt
    );

    modport slave (
        input  req_valid, opcode, addr, wdata, mem_rdata, mem_ack,
        output req_ready, rdata, ready, mem_req, mem_we, mem_addr, mem_wdata,
               hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_controller_nway.sv
// N-way set-associative write-back/write-allocate cache controller with
// true-LRU age replacement and saturating hit/miss statistics.
module cache_controller_nway #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    parameter int CNT_W  = 16
) (
    input logic                    clk,
    input logic                    rst_b,
    cache_controller_nway_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOOKUP    = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_REFILL    = 2'd3;

    logic [1:0]        r_state;
    logic              r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [WAY_W-1:0]  r_victim;
    logic              r_ready;
    logic [DATA_W-1:0] r_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS];
    logic [WAY_W-1:0]  r_age   [SETS][WAYS];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic              w_has_inv;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_old_way;
    logic [WAY_W-1:0]  w_victim;
    logic              w_victim_dirty;
    logic              w_lookup;
    logic              w_refill_done;
    logic              w_touch;
    logic [WAY_W-1:0]  w_touch_way;

    assign w_idx = r_addr[IDX_W-1:0];
    assign w_tag = r_addr[ADDR_W-1:IDX_W];

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        w_old_way = '0;
        // Scanning downwards leaves the lowest-index invalid way selected.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_idx][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end
            if (r_age[w_idx][w] == AGE_MAX) begin
                w_old_way = WAY_W'(w);
            end
        end
        w_victim = w_has_inv ? w_inv_way : w_old_way;
    end

    assign w_victim_dirty = r_valid[w_idx][w_victim] & r_dirty[w_idx][w_victim];
    assign w_lookup       = (r_state == S_LOOKUP);
    assign w_refill_done  = (r_state == S_REFILL) && bus.mem_ack;
    assign w_touch        = (w_lookup && w_hit) || w_refill_done;
    assign w_touch_way    = w_lookup ? w_hit_way : r_victim;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= S_IDLE;
            r_op        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_victim    <= '0;
            r_ready     <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op    <= bus.opcode;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (!r_op) r_rdata <= r_data[w_idx][w_hit_way];
                        if (r_hit_cnt != CNT_MAX) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_miss_cnt != CNT_MAX) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                        r_victim  <= w_victim;
                        r_mem_req <= 1'b1;
                        if (w_victim_dirty) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {r_tag[w_idx][w_victim], w_idx};
                            r_mem_wdata <= r_data[w_idx][w_victim];
                            r_state     <= S_WRITEBACK;
                        end else begin
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= r_addr;
                            r_state    <= S_REFILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    // mem_req stays high; only direction and address change.
                    if (bus.mem_ack) begin
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_addr;
                        r_state    <= S_REFILL;
                    end
                end
                default: begin
                    if (bus.mem_ack) begin
                        if (!r_op) r_rdata <= bus.mem_rdata;
                        r_mem_req <= 1'b0;
                        r_ready   <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else if (w_lookup && w_hit && r_op) begin
            r_dirty[w_idx][w_hit_way] <= 1'b1;
        end else if (w_refill_done) begin
            r_valid[w_idx][r_victim] <= 1'b1;
            r_dirty[w_idx][r_victim] <= r_op;
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (w_lookup && w_hit && r_op) begin
            r_data[w_idx][w_hit_way] <= r_wdata;
        end else if (w_refill_done) begin
            r_tag[w_idx][r_victim]  <= w_tag;
            r_data[w_idx][r_victim] <= r_op ? r_wdata : bus.mem_rdata;
        end
    end

    // NOTE: non-blocking updates mean every comparison sees the pre-access ages.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= WAY_W'(w);
                end
            end
        end else if (w_touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == w_touch_way) begin
                    r_age[w_idx][w] <= '0;
                end else if (r_age[w_idx][w] < r_age[w_idx][w_touch_way]) begin
                    r_age[w_idx][w] <= r_age[w_idx][w] + WAY_W'(1);
                end
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.ready     = r_ready;
    assign bus.rdata     = r_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.hit_cnt   = r_hit_cnt;
    assign bus.miss_cnt  = r_miss_cnt;
endmodule

// File: tb/tb_cache_controller_nway.sv
// Self-checking bench for cache_controller_nway: directed tables, handshake
// corner cases and a randomized run against a recency-list cache model.
module tb_cache_controller_nway;
    logic clk;
    logic rst_b;

    cache_controller_nway_if #(.ADDR_W(16), .DATA_W(8), .CNT_W(16)) bus ();

    cache_controller_nway #(
        .ADDR_W(16), .DATA_W(8), .WAYS(4), .SETS(16), .CNT_W(16)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [7:0]  d;
        logic        hit;
        logic [7:0]  rd;
        logic        wb;
        logic [15:0] wb_a;
        logic [7:0]  wb_d;
        int          hc;
        int          mc;
    } vec_t;

    typedef struct {
        logic [11:0] tag;
        logic [7:0]  data;
        logic        dirty;
    } line_t;

    logic [15:0] rd_q[$];
    logic [15:0] wb_a_q[$];
    logic [7:0]  wb_d_q[$];
    line_t       m_set[16][$];
    int          m_hits;
    int          m_misses;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic op, input logic [15:0] a, input logic [7:0] d,
                                input logic hit, input logic [7:0] rd, input logic wb,
                                input logic [15:0] wa, input logic [7:0] wd,
                                input int hc, input int mc);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.hit = hit; v.rd = rd;
        v.wb = wb; v.wb_a = wa; v.wb_d = wd; v.hc = hc; v.mc = mc;
        return v;
    endfunction

    // Backing memory: ack three cycles after a request phase starts.
    initial begin
        int          cnt;
        logic        ack_wb;
        logic [24:0] snap;
        cnt = 0;
        ack_wb = 1'b0;
        snap = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                cnt = 0;
                if (ack_wb && rst_b) begin
                    check("wb_to_refill_req_held", bus.mem_req, 1);
                    check("wb_to_refill_we_fall", bus.mem_we, 0);
                end
            end else if (!rst_b || !bus.mem_req) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == 1) snap = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
                if (cnt == 3) begin
                    check("mem_stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, snap);
                    ack_wb = bus.mem_we;
                    if (bus.mem_we) begin
                        wb_a_q.push_back(bus.mem_addr);
                        wb_d_q.push_back(bus.mem_wdata);
                    end else begin
                        rd_q.push_back(bus.mem_addr);
                    end
                    bus.mem_rdata = bus.mem_addr[7:0] ^ 8'hA5;
                    bus.mem_ack = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        rst_b = 1'b0;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    // Issue one request (caller sits at a negedge with the DUT idle) and compare.
    task automatic run_vec(input string nm, input vec_t v);
        int n_rd0, n_wb0, cyc;
        n_rd0 = rd_q.size();
        n_wb0 = wb_a_q.size();
        bus.req_valid = 1'b1;
        bus.opcode = v.op;
        bus.addr = v.a;
        bus.wdata = v.d;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.opcode = ~v.op;
        bus.addr = ~v.a;
        bus.wdata = ~v.d;
        check({nm, "_ready_pulse_end"}, bus.ready, 0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.ready && cyc < 100);
        check({nm, "_ready_seen"}, bus.ready, 1);
        check({nm, "_hit_latency"}, (cyc == 2) ? 1 : 0, v.hit);
        check({nm, "_req_ready"}, bus.req_ready, 1);
        if (!v.op) check({nm, "_rdata"}, bus.rdata, v.rd);
        check({nm, "_n_refill"}, rd_q.size() - n_rd0, v.hit ? 0 : 1);
        if (!v.hit && rd_q.size() > n_rd0) check({nm, "_refill_addr"}, rd_q[$], v.a);
        check({nm, "_n_wb"}, wb_a_q.size() - n_wb0, v.wb ? 1 : 0);
        if (v.wb && wb_a_q.size() > n_wb0) begin
            check({nm, "_wb_addr"}, wb_a_q[$], v.wb_a);
            check({nm, "_wb_data"}, wb_d_q[$], v.wb_d);
        end
        check({nm, "_hit_cnt"}, bus.hit_cnt, v.hc);
        check({nm, "_miss_cnt"}, bus.miss_cnt, v.mc);
    endtask

    // Reference: each set is a list ordered most- to least-recently used.
    task automatic model_access(input vec_t vi, output vec_t vo);
        int          s, found;
        logic [11:0] t;
        line_t       ln, vic;
        vo = vi;
        vo.wb = 1'b0; vo.wb_a = '0; vo.wb_d = '0;
        s = int'(vi.a[3:0]);
        t = vi.a[15:4];
        found = -1;
        for (int i = 0; i < m_set[s].size(); i++) begin
            if (m_set[s][i].tag == t) found = i;
        end
        if (found >= 0) begin
            ln = m_set[s][found];
            m_set[s].delete(found);
            m_hits++;
            vo.hit = 1'b1;
        end else begin
            m_misses++;
            vo.hit = 1'b0;
            if (m_set[s].size() == 4) begin
                vic = m_set[s].pop_back();
                if (vic.dirty) begin
                    vo.wb = 1'b1;
                    vo.wb_a = {vic.tag, vi.a[3:0]};
                    vo.wb_d = vic.data;
                end
            end
            ln.tag = t;
            ln.data = vi.a[7:0] ^ 8'hA5;
            ln.dirty = 1'b0;
        end
        if (vi.op) begin
            ln.data = vi.d;
            ln.dirty = 1'b1;
        end
        vo.rd = ln.data;
        m_set[s].push_front(ln);
        vo.hc = m_hits;
        vo.mc = m_misses;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tab1[9];
        vec_t tab2[9];
        vec_t v, ve;
        int   cyc, n_ready;

        bus.req_valid = 1'b0;
        bus.opcode = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;

        tab1[0] = mk(0, 16'h0012, 8'h00, 0, 8'hB7, 0, 16'h0000, 8'h00, 0, 1);
        tab1[1] = mk(0, 16'h0012, 8'h00, 1, 8'hB7, 0, 16'h0000, 8'h00, 1, 1);
        tab1[2] = mk(1, 16'h0012, 8'h3C, 1, 8'h00, 0, 16'h0000, 8'h00, 2, 1);
        tab1[3] = mk(0, 16'h0012, 8'h00, 1, 8'h3C, 0, 16'h0000, 8'h00, 3, 1);
        tab1[4] = mk(0, 16'h0112, 8'h00, 0, 8'hB7, 0, 16'h0000, 8'h00, 3, 2);
        tab1[5] = mk(0, 16'h0212, 8'h00, 0, 8'hB7, 0, 16'h0000, 8'h00, 3, 3);
        tab1[6] = mk(0, 16'h0312, 8'h00, 0, 8'hB7, 0, 16'h0000, 8'h00, 3, 4);
        tab1[7] = mk(0, 16'h0412, 8'h00, 0, 8'hB7, 1, 16'h0012, 8'h3C, 3, 5);
        tab1[8] = mk(0, 16'h0012, 8'h00, 0, 8'hB7, 0, 16'h0000, 8'h00, 3, 6);

        tab2[0] = mk(0, 16'h0012, 8'h00, 0, 8'hB7, 0, 16'h0000, 8'h00, 0, 1);
        tab2[1] = mk(0, 16'h0112, 8'h00, 0, 8'hB7, 0, 16'h0000, 8'h00, 0, 2);
        tab2[2] = mk(0, 16'h0212, 8'h00, 0, 8'hB7, 0, 16'h0000, 8'h00, 0, 3);
        tab2[3] = mk(0, 16'h0312, 8'h00, 0, 8'hB7, 0, 16'h0000, 8'h00, 0, 4);
        tab2[4] = mk(0, 16'h0012, 8'h00, 1, 8'hB7, 0, 16'h0000, 8'h00, 1, 4);
        tab2[5] = mk(0, 16'h0412, 8'h00, 0, 8'hB7, 0, 16'h0000, 8'h00, 1, 5);
        tab2[6] = mk(0, 16'h0012, 8'h00, 1, 8'hB7, 0, 16'h0000, 8'h00, 2, 5);
        tab2[7] = mk(0, 16'h0212, 8'h00, 1, 8'hB7, 0, 16'h0000, 8'h00, 3, 5);
        tab2[8] = mk(0, 16'h0312, 8'h00, 1, 8'hB7, 0, 16'h0000, 8'h00, 4, 5);

        do_reset();
        check("rst_ready", bus.ready, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_hit_cnt", bus.hit_cnt, 0);
        check("rst_miss_cnt", bus.miss_cnt, 0);

        for (int i = 0; i < 9; i++) run_vec($sformatf("t1_%0d", i), tab1[i]);

        do_reset();
        for (int i = 0; i < 9; i++) run_vec($sformatf("t2_%0d", i), tab2[i]);

        // Reset while the refill is still waiting for its ack.
        do_reset();
        bus.req_valid = 1'b1;
        bus.opcode = 1'b0;
        bus.addr = 16'h0040;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        cyc = 0;
        while (!bus.mem_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("mm_mem_req_seen", bus.mem_req, 1);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("mm_mem_req_drop", bus.mem_req, 0);
        check("mm_miss_cnt", bus.miss_cnt, 0);
        check("mm_hit_cnt", bus.hit_cnt, 0);
        n_ready = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.ready) n_ready++;
        end
        check("mm_no_ready", n_ready, 0);
        rst_b = 1'b1;
        run_vec("mm_reread", mk(0, 16'h0040, 8'h00, 0, 8'hE5, 0, 16'h0000, 8'h00, 0, 1));

        // Randomized traffic over a few conflicting sets.
        do_reset();
        for (int s = 0; s < 16; s++) m_set[s].delete();
        m_hits = 0;
        m_misses = 0;
        for (int i = 0; i < 300; i++) begin
            v.op = 1'($urandom_range(0, 1));
            v.a  = 16'($urandom_range(0, 5) * 16'h0130 + $urandom_range(0, 2));
            v.d  = 8'($urandom);
            model_access(v, ve);
            run_vec("rnd", ve);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cache_controller_nway.md
# cache_controller_nway

Parametrised N-way set-associative, write-back, write-allocate cache controller with true-LRU replacement. It sits between a single requester (CPU side) and a word-addressed backing memory with a req/ack handshake, and generalises the fixed four-way controller in width, depth and associativity. It adds dirty-line write-back and saturating hit/miss statistics.

## Interface
- ADDR_W, 16, word address width
- DATA_W, 8, data word width; one word per line
- WAYS, 4, associativity; power of 2, ≥2
- SETS, 16, number of sets; power of 2, ≥2; IDX_W = log2(SETS), TAG_W = ADDR_W-IDX_W
- CNT_W, 16, statistics counter width
- clk  in  1  single clock, all state on rising edge
- rst_b  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- opcode  in  1  0 = read, 1 = write
- addr  in  ADDR_W  request word address; index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W]
- wdata  in  DATA_W  write data
- req_ready  out  1  controller in IDLE, can accept
- rdata  out  DATA_W  read data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write-back, 0 = refill read
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  write-back data
- mem_rdata  in  DATA_W  refill data, sampled with mem_ack
- mem_ack  in  1  one-cycle memory completion
- hit_cnt  out  CNT_W  saturating hit count
- miss_cnt  out  CNT_W  saturating miss count

## Operation
- States: IDLE, LOOKUP, WRITEBACK, REFILL.
- IDLE: req_ready=1; edge with req_valid=1 captures opcode/addr/wdata → LOOKUP. Later input changes are ignored until the next acceptance.
- LOOKUP: compare tag against all valid ways of the set.
  - Hit: a read returns the way's data; a write stores wdata and sets dirty. LRU is updated, hit_cnt increments, ready=1, → IDLE.
  - Miss: miss_cnt increments. Victim = lowest-index invalid way, else the way with age = WAYS-1. Dirty victim → WRITEBACK, otherwise → REFILL.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data. On mem_ack → REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr=captured addr. On mem_ack, install the line in the victim way: valid=1, tag stored.
  - Read: data=mem_rdata, dirty=0, rdata=mem_rdata.
  - Write: data=wdata, dirty=1.
  - Then update LRU, ready=1, → IDLE.
- LRU: each way holds a log2(WAYS)-bit age. On access to way w, every way with age < age[w] increments, then age[w]=0. Ages within a set always form a permutation of 0..WAYS-1.
- mem_ack outside WRITEBACK/REFILL is ignored. req_valid outside IDLE is ignored (req_ready=0).
- Counters saturate at 2^CNT_W-1.

## Timing
- Reset (async, immediate):
  - state IDLE; all valid and dirty bits cleared; age[w]=w in every set.
  - ready=0, rdata=0, req_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, hit_cnt=0, miss_cnt=0.
- Hit latency: request accepted at edge E, ready high for exactly one cycle after edge E+1, req_ready high again in that same cycle.
- Clean miss: mem_req rises after edge E+1. With mem_ack sampled at edge A, ready is high in the cycle after A.
- Dirty miss: WRITEBACK handshake completes first. mem_req stays high continuously across the WRITEBACK→REFILL transition, and mem_we falls at the transition.
- mem_req, mem_we, mem_addr and mem_wdata are stable while mem_req=1 and ack is pending.
- Reset mid-miss: the transaction is aborted, mem_req drops immediately, no line is installed, no ready is issued.
- Back-to-back: a new request can be accepted in the ready cycle's following edge (IDLE with req_valid held high).

## Test plan
Configuration: defaults. Memory model: mem_rdata = addr[7:0]^8'hA5, mem_ack 3 cycles after mem_req rises, write-backs recorded.
- Reset, read 0x0012 → one mem read at 0x0012, ready with rdata=0xB7, miss_cnt=1, hit_cnt=0.
- Read 0x0012 again → ready one cycle after the LOOKUP edge, rdata=0xB7, no mem_req, hit_cnt=1.
- Write 0x0012 with 0x3C → hit, no mem_req; read 0x0012 → rdata=0x3C, hit_cnt=3.
- Read 0x0112, 0x0212, 0x0312 (set 2 full), then read 0x0412 → LRU victim is the dirty 0x0012. Required: write-back mem_we=1, mem_addr=0x0012, mem_wdata=0x3C, then refill at 0x0412 with rdata=0xB7. A subsequent read of 0x0012 misses.
- After reset, fill set 2 with 0x0012..0x0312, re-read 0x0012, then read 0x0412 → victim is 0x0112 (clean, no write-back). Reads of 0x0012, 0x0212, 0x0312 then hit.
- Assert rst_b=0 while waiting for mem_ack in REFILL → mem_req=0 immediately, ready never pulses, counters 0. Reading the same address after release misses.
